// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: streams an NUM_OF_WORDS-word message from a word
// memory and presents it as a sequence of 512-bit blocks with the
// 0x80000000 end marker, zero fill and 32-bit bit-length appended.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, input_addr   begin a message at word address input_addr (IDLE only)
//   mem_rd_en, mem_addr memory read request; data returns one cycle later
//   mem_read_data       memory read data
//   blk_data            padded block, word 0 in [511:480]
//   blk_valid/blk_ready block handshake towards the hash core
//   blk_last            block being offered is the final one
//   busy, done          not idle / one-cycle pulse after final handshake
module sha256_block_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  input_addr,
  output logic         mem_rd_en,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int          NUM_BLKS = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [6:0]  LAST_BLK = 7'(NUM_BLKS - 1);
  localparam logic [15:0] N_WORDS  = 16'(NUM_OF_WORDS);
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [4:0]     r_cnt;      // FILL cycle 0..16
  logic [6:0]     r_blk;      // block index within the message
  logic [15:0]    r_addr;     // latched base address
  logic [511:0]   r_blk_data;
  logic           r_blk_valid;
  logic           r_blk_last;
  logic           r_busy;
  logic           r_done;

  logic           w_hs;
  logic           w_is_last;
  logic [15:0]    w_base_g;
  logic [15:0]    w_req_g;
  logic [3:0]     w_cap_k;
  logic [15:0]    w_cap_g;
  logic [31:0]    w_cap_word;
  logic           w_cap_en;

  assign w_is_last = (r_blk == LAST_BLK);
  assign w_hs      = (r_state == ST_OFFER) && blk_ready;
  assign w_base_g  = 16'({r_blk, 4'b0000});
  assign w_req_g   = w_base_g + {12'h000, r_cnt[3:0]};
  // Slot k is captured in FILL cycle k+1; at cycle 16 the low nibble wraps to 0, giving slot 15.
  assign w_cap_k   = r_cnt[3:0] - 4'd1;
  assign w_cap_g   = w_base_g + {12'h000, w_cap_k};
  assign w_cap_en  = (r_state == ST_FILL) && (r_cnt != 5'd0);

  // Read request is decoded straight from the slot counter so it lands in slot k's own cycle.
  assign mem_rd_en = (r_state == ST_FILL) && !r_cnt[4] && (w_req_g < N_WORDS);
  assign mem_addr  = mem_rd_en ? (r_addr + w_req_g) : 16'h0000;

  assign blk_data  = r_blk_data;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;
  assign busy      = r_busy;
  assign done      = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FILL;
        else       w_next = ST_IDLE;
      end
      ST_FILL: begin
        if (r_cnt == 5'd16) w_next = ST_OFFER;
        else                w_next = ST_FILL;
      end
      ST_OFFER: begin
        if (w_hs && w_is_last) w_next = ST_IDLE;
        else if (w_hs)         w_next = ST_FILL;
        else                   w_next = ST_OFFER;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Word selection for the slot being captured; the last block's tail carries the length.
  always_comb begin
    w_cap_word = 32'h0000_0000;
    if (w_is_last && (w_cap_k == 4'd15)) begin
      w_cap_word = LEN_BITS;
    end else if (w_is_last && (w_cap_k == 4'd14)) begin
      w_cap_word = 32'h0000_0000;
    end else if (w_cap_g < N_WORDS) begin
      w_cap_word = mem_read_data;
    end else if (w_cap_g == N_WORDS) begin
      w_cap_word = 32'h8000_0000;
    end else begin
      w_cap_word = 32'h0000_0000;
    end
  end

  // Slot counter, block counter and latched base address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 5'd0;
      r_blk  <= 7'd0;
      r_addr <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr <= input_addr;
            r_blk  <= 7'd0;
            r_cnt  <= 5'd0;
          end
        end
        ST_FILL: begin
          if (r_cnt == 5'd16) r_cnt <= 5'd0;
          else                r_cnt <= r_cnt + 5'd1;
        end
        ST_OFFER: begin
          if (w_hs && !w_is_last) r_blk <= r_blk + 7'd1;
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  // Block assembly: words shift in from the bottom so word 0 ends up in the top lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_data <= 512'h0;
    end else if (w_cap_en) begin
      r_blk_data <= {r_blk_data[479:0], w_cap_word};
    end
  end

  // Registered status outputs, all derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_blk_valid <= (w_next == ST_OFFER);
      r_blk_last  <= (w_next == ST_OFFER) && w_is_last;
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= w_hs && w_is_last;
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Testbench for sha256_block_padder: several instances with different message
// lengths share one word memory; a queue-based padding model supplies every
// expected block and read address.
module tb_sha256_block_padder;

  localparam int NI = 6;
  localparam int NS [NI] = '{1, 13, 14, 20, 2, 29};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s    [NI];
  logic [15:0]  in_addr_s  [NI];
  logic         rd_en_s    [NI];
  logic [15:0]  maddr_s    [NI];
  logic [511:0] bdata_s    [NI];
  logic         bvalid_s   [NI];
  logic         bready_s   [NI];
  logic         blast_s    [NI];
  logic         busy_s     [NI];
  logic         done_s     [NI];

  logic [31:0]  mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  int unsigned  exp_w [$];
  logic [15:0]  exp_a [$];
  logic [15:0]  obs_a [$];
  logic [511:0] last_blk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [31:0] rdata;
      sha256_block_padder #(.NUM_OF_WORDS(NS[gi])) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_s[gi]),
        .input_addr    (in_addr_s[gi]),
        .mem_rd_en     (rd_en_s[gi]),
        .mem_addr      (maddr_s[gi]),
        .mem_read_data (rdata),
        .blk_data      (bdata_s[gi]),
        .blk_valid     (bvalid_s[gi]),
        .blk_ready     (bready_s[gi]),
        .blk_last      (blast_s[gi]),
        .busy          (busy_s[gi]),
        .done          (done_s[gi])
      );
      // Memory returns data the cycle after a request, garbage otherwise.
      always @(posedge clk) rdata <= rd_en_s[gi] ? mem[maddr_s[gi]] : $urandom;
    end
  endgenerate

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Padding model: message words, end marker, zeros to 14 mod 16, then 64-bit length.
  task automatic build_model(input int n, input logic [15:0] addr);
    logic [15:0] a;
    exp_w.delete();
    exp_a.delete();
    for (int g = 0; g < n; g++) begin
      a = addr + 16'(g);
      exp_a.push_back(a);
      exp_w.push_back(mem[a]);
    end
    exp_w.push_back(32'h8000_0000);
    while (exp_w.size() % 16 != 14) exp_w.push_back(32'h0);
    exp_w.push_back(32'h0);
    exp_w.push_back(32'(32 * n));
  endtask

  function automatic logic [511:0] exp_block(input int b);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[511 - 32*k -: 32] = exp_w[16*b + k];
    return r;
  endfunction

  task automatic run_msg(input int idx, input logic [15:0] addr, input int stall, input bit mid_start);
    int n, nb, b, t, wait_c, dones;
    bit in_offer, fin;
    logic [511:0] held;
    logic held_last;
    n = NS[idx];
    build_model(n, addr);
    nb = exp_w.size() / 16;
    obs_a.delete();
    @(negedge clk);
    start_s[idx] = 1'b1;
    in_addr_s[idx] = addr;
    @(negedge clk);
    start_s[idx] = 1'b0;
    t = 0; b = 0; wait_c = 0; dones = 0; in_offer = 1'b0; fin = 1'b0;
    held = '0; held_last = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (mid_start && b == 0 && t == 5) begin
        start_s[idx] = 1'b1;
        in_addr_s[idx] = 16'h5555;
      end else begin
        start_s[idx] = 1'b0;
      end
      if (rd_en_s[idx]) obs_a.push_back(maddr_s[idx]);
      if (done_s[idx]) begin
        dones++;
        chk("done_after_all_blocks", 512'(b), 512'(nb));
        chk("busy_low_at_done", 512'(busy_s[idx]), 512'(0));
        fin = 1'b1;
      end
      if (bvalid_s[idx]) begin
        if (!in_offer) begin
          in_offer = 1'b1;
          wait_c = 0;
          chk("valid_latency", 512'(t), 512'(17));
          held = bdata_s[idx];
          held_last = blast_s[idx];
          chk("blk_data", held, exp_block(b));
          chk("blk_last", 512'(held_last), 512'(b == nb - 1));
          last_blk = held;
        end else begin
          chk("data_stable", bdata_s[idx], held);
          chk("last_stable", 512'(blast_s[idx]), 512'(held_last));
        end
        chk("no_read_in_offer", 512'(rd_en_s[idx]), 512'(0));
        if (wait_c >= stall) begin
          bready_s[idx] = 1'b1;
          in_offer = 1'b0;
          b++;
          t = -1;
        end else begin
          bready_s[idx] = 1'b0;
          wait_c++;
        end
      end else begin
        bready_s[idx] = 1'($urandom_range(0, 1));
      end
      t++;
    end
    bready_s[idx] = 1'b0;
    start_s[idx] = 1'b0;
    chk("finished_in_budget", 512'(fin), 512'(1));
    chk("block_count", 512'(b), 512'(nb));
    repeat (3) begin
      @(negedge clk);
      chk("done_single_pulse", 512'(done_s[idx]), 512'(0));
      chk("idle_not_busy", 512'(busy_s[idx]), 512'(0));
      chk("idle_no_read", 512'(rd_en_s[idx]), 512'(0));
    end
    chk("read_count", 512'(obs_a.size()), 512'(exp_a.size()));
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      chk("read_addr", 512'(obs_a[i]), 512'(exp_a[i]));
  endtask

  logic [511:0] k031;

  initial begin
    k031 = {32'h6162_6364, 32'h8000_0000, 416'h0, 32'h0000_0020};
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      in_addr_s[i] = 16'h0000;
      bready_s[i] = 1'b0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0100] = 32'h6162_6364;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", 512'(bvalid_s[i]), 512'(0));
      chk("rst_busy", 512'(busy_s[i]), 512'(0));
      chk("rst_rd_en", 512'(rd_en_s[i]), 512'(0));
      chk("rst_data", bdata_s[i], 512'(0));
    end
    rst_n = 1'b1;

    // Single-word message with fixed contents.
    run_msg(0, 16'h0100, 0, 1'b0);
    chk("n1_block_constant", last_blk, k031);

    // Block-count boundaries and stalled offers with a start during FILL.
    run_msg(1, 16'($urandom), 1, 1'b0);
    run_msg(2, 16'($urandom), 2, 1'b0);
    run_msg(3, 16'($urandom), 5, 1'b1);
    run_msg(5, 16'($urandom), 0, 1'b0);

    // Address wrap.
    run_msg(4, 16'hFFFF, 1, 1'b0);

    // Reset during FILL cycle 8 of block 0.
    @(negedge clk);
    start_s[0] = 1'b1;
    in_addr_s[0] = 16'h0100;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", 512'(busy_s[0]), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 512'(bvalid_s[0]), 512'(0));
    chk("mid_rst_last", 512'(blast_s[0]), 512'(0));
    chk("mid_rst_rd_en", 512'(rd_en_s[0]), 512'(0));
    chk("mid_rst_addr", 512'(maddr_s[0]), 512'(0));
    chk("mid_rst_busy", 512'(busy_s[0]), 512'(0));
    chk("mid_rst_data", bdata_s[0], 512'(0));
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", 512'(done_s[0]), 512'(0));
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_done", 512'(done_s[0]), 512'(0));
    end
    run_msg(0, 16'h0100, 1, 1'b0);
    chk("n1_after_reset", last_blk, k031);

    // Randomized messages across all lengths.
    for (int r = 0; r < 8; r++)
      run_msg($urandom_range(0, NI - 1), 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
